// File: rtl/grid_pkg.sv
// Shared geometry, widths and types for the board grid scan-out and its RAM port.
package grid_pkg;

  localparam int ORIGIN   = 50;
  localparam int CELL     = 50;
  localparam int N        = 10;
  localparam int DW       = 8;
  localparam int HW       = 12;
  localparam int OW       = 6;
  localparam int GRID_END = ORIGIN + N * CELL;

  localparam int NUM_AXES = 2;
  localparam int AX_X     = 0;
  localparam int AX_Y     = 1;

  typedef logic [6:0]    cell_addr_t;
  typedef logic [3:0]    cell_idx_t;
  typedef logic [OW-1:0] cell_off_t;
  typedef logic [HW-1:0] pix_t;

  typedef struct packed {
    logic          we;
    cell_addr_t    addr;
    logic [DW-1:0] wdata;
  } ram_cmd_t;

  function automatic cell_addr_t cell_addr(input cell_idx_t row, input cell_idx_t col);
    logic [31:0] a;
    a = 32'(row) * 32'(N) + 32'(col);
    return a[6:0];
  endfunction

endpackage

// File: rtl/grid_axis_counter.sv
// One grid axis: division-free cell index / in-cell offset tracking for a pixel
// coordinate, with load at the grid origin and index saturation on the far edge.
module grid_axis_counter
  import grid_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  pix_t      pos,
  input  logic      step,
  output logic      in_range,
  output logic      on_edge,
  output cell_idx_t idx_d,
  output cell_idx_t idx_q,
  output cell_off_t off_d,
  output cell_off_t off_q
);

  always_comb begin
    in_range = (pos >= pix_t'(ORIGIN)) && (pos <= pix_t'(GRID_END));
    on_edge  = (pos == pix_t'(GRID_END));
    idx_d    = idx_q;
    off_d    = off_q;
    if (step) begin
      if (pos == pix_t'(ORIGIN)) begin
        idx_d = '0;
        off_d = '0;
      end else if (in_range) begin
        if (off_q == cell_off_t'(CELL - 1)) begin
          off_d = '0;
          // The closing edge line still belongs to the last cell.
          if (idx_q != cell_idx_t'(N - 1)) idx_d = idx_q + 4'd1;
        end else begin
          off_d = off_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      off_q <= '0;
    end else begin
      idx_q <= idx_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/grid_scan_controller.sv
// Board grid scan-out for the VGA painters plus single-port board RAM arbitration:
// video cell prefetch owns the port in its slots, game logic gets every other cycle.
module grid_scan_controller
  import grid_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [11:0]   hdata,
  input  logic [11:0]   vdata,
  output logic          in_grid,
  output logic          on_line,
  output logic [3:0]    cell_col,
  output logic [3:0]    cell_row,
  output logic [5:0]    off_x,
  output logic [5:0]    off_y,
  output logic [DW-1:0] cell_data,
  output logic [6:0]    ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          game_req,
  input  logic          game_we,
  input  logic [6:0]    game_addr,
  input  logic [DW-1:0] game_wdata,
  output logic          game_gnt,
  output logic          game_rdata_valid,
  output logic [DW-1:0] game_rdata
);

  // Slot -> command register -> RAM output register.
  localparam int STAGES = 2;

  logic [NUM_AXES-1:0][HW-1:0] axis_pos;
  logic [NUM_AXES-1:0]         axis_step;
  logic [NUM_AXES-1:0]         axis_in;
  logic [NUM_AXES-1:0]         axis_edge;
  cell_idx_t [NUM_AXES-1:0]    axis_idx_d;
  cell_idx_t [NUM_AXES-1:0]    axis_idx_q;
  cell_off_t [NUM_AXES-1:0]    axis_off_d;
  cell_off_t [NUM_AXES-1:0]    axis_off_q;

  logic              fetch_slot;
  cell_idx_t         next_col;
  logic              in_grid_d, in_grid_q;
  logic              on_line_d, on_line_q;
  logic [DW-1:0]     cell_data_d, cell_data_q;
  ram_cmd_t          ram_cmd_d, ram_cmd_q;
  logic [STAGES-1:0] fetch_vld_d, fetch_vld_q;
  logic [STAGES-1:0] rd_vld_d, rd_vld_q;

  assign axis_pos[AX_X]  = hdata;
  assign axis_pos[AX_Y]  = vdata;
  assign axis_step[AX_X] = 1'b1;
  assign axis_step[AX_Y] = (hdata == '0);

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    grid_axis_counter u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .pos      (axis_pos[a]),
      .step     (axis_step[a]),
      .in_range (axis_in[a]),
      .on_edge  (axis_edge[a]),
      .idx_d    (axis_idx_d[a]),
      .idx_q    (axis_idx_q[a]),
      .off_d    (axis_off_d[a]),
      .off_q    (axis_off_q[a])
    );
  end

  // Slots sit two pixels ahead of each cell boundary so the word lands on the boundary.
  always_comb begin
    fetch_slot = 1'b0;
    for (int k = 0; k < N; k++)
      if (hdata == pix_t'(ORIGIN + k * CELL - 2)) fetch_slot = 1'b1;
    fetch_slot = fetch_slot & axis_in[AX_Y] & ~axis_edge[AX_Y];
    // Before the first cell the x counter still holds the previous line's state.
    next_col = (hdata == pix_t'(ORIGIN - 2)) ? '0 : axis_idx_d[AX_X] + 4'd1;
  end

  assign game_gnt = game_req & ~fetch_slot;

  always_comb begin
    in_grid_d   = axis_in[AX_X] & axis_in[AX_Y];
    on_line_d   = in_grid_d & ((axis_off_d[AX_X] == '0) | (axis_off_d[AX_Y] == '0) |
                               axis_edge[AX_X] | axis_edge[AX_Y]);
    cell_data_d = fetch_vld_q[STAGES-1] ? ram_rdata : cell_data_q;

    ram_cmd_d    = ram_cmd_q;
    ram_cmd_d.we = 1'b0;
    if (fetch_slot) begin
      ram_cmd_d.addr = cell_addr(axis_idx_d[AX_Y], next_col);
    end else if (game_gnt) begin
      ram_cmd_d.we    = game_we;
      ram_cmd_d.addr  = game_addr;
      ram_cmd_d.wdata = game_wdata;
    end

    fetch_vld_d = {fetch_vld_q[STAGES-2:0], fetch_slot};
    rd_vld_d    = {rd_vld_q[STAGES-2:0], game_gnt & ~game_we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_grid_q   <= 1'b0;
      on_line_q   <= 1'b0;
      cell_data_q <= '0;
      ram_cmd_q   <= '0;
      fetch_vld_q <= '0;
      rd_vld_q    <= '0;
    end else begin
      in_grid_q   <= in_grid_d;
      on_line_q   <= on_line_d;
      cell_data_q <= cell_data_d;
      ram_cmd_q   <= ram_cmd_d;
      fetch_vld_q <= fetch_vld_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  assign in_grid          = in_grid_q;
  assign on_line          = on_line_q;
  assign cell_col         = axis_idx_q[AX_X];
  assign cell_row         = axis_idx_q[AX_Y];
  assign off_x            = axis_off_q[AX_X];
  assign off_y            = axis_off_q[AX_Y];
  assign cell_data        = cell_data_q;
  assign ram_addr         = ram_cmd_q.addr;
  assign ram_we           = ram_cmd_q.we;
  assign ram_wdata        = ram_cmd_q.wdata;
  assign game_rdata_valid = rd_vld_q[STAGES-1];
  assign game_rdata       = game_rdata_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_grid_scan_controller.sv
// Bench for grid_scan_controller: board RAM model, game-read scoreboard retired in
// the per-cycle step, and one task per scenario.
module tb_grid_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] hdata = '0;
  logic [11:0] vdata = '0;
  logic        in_grid, on_line;
  logic [3:0]  cell_col, cell_row;
  logic [5:0]  off_x, off_y;
  logic [7:0]  cell_data;
  logic [6:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        game_req = 1'b0;
  logic        game_we = 1'b0;
  logic [6:0]  game_addr = '0;
  logic [7:0]  game_wdata = '0;
  logic        game_gnt, game_rdata_valid;
  logic [7:0]  game_rdata;

  logic [7:0]  mem [0:127];
  logic [7:0]  ref_mem [0:127];
  logic        mem_load = 1'b1;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  grid_scan_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hdata            (hdata),
    .vdata            (vdata),
    .in_grid          (in_grid),
    .on_line          (on_line),
    .cell_col         (cell_col),
    .cell_row         (cell_row),
    .off_x            (off_x),
    .off_y            (off_y),
    .cell_data        (cell_data),
    .ram_addr         (ram_addr),
    .ram_we           (ram_we),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .game_req         (game_req),
    .game_we          (game_we),
    .game_addr        (game_addr),
    .game_wdata       (game_wdata),
    .game_gnt         (game_gnt),
    .game_rdata_valid (game_rdata_valid),
    .game_rdata       (game_rdata)
  );

  always #5 clk = ~clk;

  // Single-port board RAM, registered read (old data on read-during-write).
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // One clock step; game read pulses seen this cycle retire the scoreboard head.
  task automatic tick();
    exp_t e;
    #2;
    if (game_rdata_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_valid_unexpected cycle %0d: got valid=1 data=%h, want no pulse", cyc, game_rdata);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || game_rdata !== e.data) begin
          miscompares++;
          $display("FAIL rd_data cycle %0d data %h, want cycle %0d data %h", cyc, game_rdata, e.cyc, e.data);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_valid_missing cycle %0d: got valid=0, want pulse with data %h", cyc, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic px(input int h, input int v);
    hdata = 12'(h);
    vdata = 12'(v);
    tick();
  endtask

  // Lines outside the checked region only need their hdata==0 cycle for the y counter.
  task automatic short_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = 0; h < 10; h++) px(h, v);
  endtask

  task automatic test_reset();
    logic [54:0] outs;
    short_lines(0, 49);
    for (int h = 0; h <= 120; h++) px(h, 50);
    vectors++;
    if (in_grid !== 1'b1 || cell_col !== 4'd1) begin
      miscompares++;
      $display("FAIL pre_reset in_grid=%b col=%0d, want in_grid=1 col=1", in_grid, cell_col);
    end
    hdata = 12'd121;
    rst_n = 1'b0;
    #1;
    outs = {in_grid, on_line, cell_col, cell_row, off_x, off_y, cell_data,
            ram_addr, ram_we, ram_wdata, game_rdata_valid, game_rdata};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h, want 0", outs);
    end
    tick();
    outs = {in_grid, on_line, cell_col, cell_row, off_x, off_y, cell_data,
            ram_addr, ram_we, ram_wdata, game_rdata_valid, game_rdata};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_hold got %h, want 0", outs);
    end
    rst_n = 1'b1;
    short_lines(0, 49);
    for (int h = 0; h <= 50; h++) px(h, 50);
    vectors++;
    if ({in_grid, on_line, cell_row, cell_col, off_x, off_y} !== {1'b1, 1'b1, 4'd0, 4'd0, 6'd0, 6'd0}) begin
      miscompares++;
      $display("FAIL first_pixel in_grid=%b on_line=%b row=%0d col=%0d ox=%0d oy=%0d, want 1 1 0 0 0 0",
               in_grid, on_line, cell_row, cell_col, off_x, off_y);
    end
    for (int h = 51; h <= 100; h++) px(h, 50);
    vectors++;
    if (cell_col !== 4'd1 || off_x !== 6'd0 || cell_data !== ref_mem[1]) begin
      miscompares++;
      $display("FAIL cell1_fetch col=%0d ox=%0d data=%h, want col=1 ox=0 data=%h", cell_col, off_x, cell_data, ref_mem[1]);
    end
  endtask

  task automatic test_frame_scan();
    short_lines(0, 259);
    for (int h = 0; h <= 560; h++) begin
      px(h, 260);
      if (h == 175) begin
        vectors++;
        if (cell_col !== 4'd2 || off_x !== 6'd25) begin
          miscompares++;
          $display("FAIL scan_x col=%0d ox=%0d, want col=2 ox=25", cell_col, off_x);
        end
        vectors++;
        if (cell_row !== 4'd4 || off_y !== 6'd10) begin
          miscompares++;
          $display("FAIL scan_y row=%0d oy=%0d, want row=4 oy=10", cell_row, off_y);
        end
        vectors++;
        if (cell_data !== ref_mem[42] || on_line !== 1'b0 || in_grid !== 1'b1) begin
          miscompares++;
          $display("FAIL scan_cell data=%h on_line=%b in_grid=%b, want data=%h on_line=0 in_grid=1",
                   cell_data, on_line, in_grid, ref_mem[42]);
        end
      end
      if (h == 550) begin
        vectors++;
        if (cell_col !== 4'd9 || on_line !== 1'b1 || in_grid !== 1'b1) begin
          miscompares++;
          $display("FAIL right_edge col=%0d on_line=%b in_grid=%b, want col=9 on_line=1 in_grid=1",
                   cell_col, on_line, in_grid);
        end
      end
      if (h == 551) begin
        vectors++;
        if (in_grid !== 1'b0 || on_line !== 1'b0) begin
          miscompares++;
          $display("FAIL past_edge in_grid=%b on_line=%b, want 0 0", in_grid, on_line);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    bit   slot;
    exp_t e;
    game_req  = 1'b1;
    game_we   = 1'b0;
    game_addr = 7'd5;
    for (int h = 0; h < 800; h++) begin
      hdata = 12'(h);
      vdata = 12'd100;
      #1;
      slot = (h >= 48) && (h <= 498) && ((h - 48) % 50 == 0);
      vectors++;
      if (game_gnt !== !slot) begin
        miscompares++;
        $display("FAIL gnt h=%0d got %b, want %b", h, game_gnt, !slot);
      end
      if (!slot) begin
        e.cyc  = cyc + 2;
        e.data = ref_mem[5];
        exp_q.push_back(e);
      end
      tick();
    end
    game_req = 1'b0;
  endtask

  task automatic test_game_write();
    for (int h = 0; h <= 20; h++) begin
      hdata      = 12'(h);
      vdata      = 12'd0;
      game_req   = (h == 10);
      game_we    = 1'b1;
      game_addr  = 7'd37;
      game_wdata = 8'hA5;
      #1;
      if (h == 10) begin
        vectors++;
        if (game_gnt !== 1'b1) begin
          miscompares++;
          $display("FAIL wr_gnt got %b, want 1", game_gnt);
        end
      end
      tick();
      if (h == 10) begin
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== 7'd37 || ram_wdata !== 8'hA5) begin
          miscompares++;
          $display("FAIL wr_cmd we=%b addr=%0d wdata=%h, want 1 37 a5", ram_we, ram_addr, ram_wdata);
        end
      end
    end
    game_req = 1'b0;
    game_we  = 1'b0;
    ref_mem[37] = 8'hA5;
    short_lines(0, 209);
    for (int h = 0; h <= 460; h++) begin
      px(h, 210);
      if (h == 405) begin
        vectors++;
        if (cell_row !== 4'd3 || cell_col !== 4'd7 || cell_data !== ref_mem[37]) begin
          miscompares++;
          $display("FAIL wr_cell row=%0d col=%0d data=%h, want 3 7 %h", cell_row, cell_col, cell_data, ref_mem[37]);
        end
      end
      if (h == 455) begin
        vectors++;
        if (cell_col !== 4'd8 || cell_data !== ref_mem[38]) begin
          miscompares++;
          $display("FAIL next_cell col=%0d data=%h, want 8 %h", cell_col, cell_data, ref_mem[38]);
        end
      end
    end
  endtask

  task automatic test_game_read();
    exp_t e;
    game_we   = 1'b0;
    game_addr = 7'd99;
    for (int h = 0; h <= 610; h++) begin
      hdata    = 12'(h);
      vdata    = 12'd300;
      game_req = (h == 600);
      #1;
      if (h == 600) begin
        vectors++;
        if (game_gnt !== 1'b1) begin
          miscompares++;
          $display("FAIL rd_gnt got %b, want 1", game_gnt);
        end
        e.cyc  = cyc + 2;
        e.data = ref_mem[99];
        exp_q.push_back(e);
      end
      tick();
    end
    game_req = 1'b0;
  endtask

  task automatic test_reset_inflight();
    for (int h = 0; h <= 20; h++) begin
      hdata      = 12'(h);
      vdata      = 12'd300;
      game_req   = (h == 19) || (h == 20);
      game_we    = (h == 20);
      game_addr  = (h == 19) ? 7'd37 : 7'd50;
      game_wdata = 8'h3C;
      tick();
    end
    game_req = 1'b0;
    game_we  = 1'b0;
    vectors++;
    if (ram_we !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_we got %b, want 1", ram_we);
    end
    hdata = 12'd21;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ram_we !== 1'b0 || game_rdata_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_reset we=%b valid=%b, want 0 0", ram_we, game_rdata_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int h = 22; h <= 30; h++) px(h, 300);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
    repeat (2) @(posedge clk);
    #1;
    mem_load = 1'b0;
    rst_n    = 1'b1;
    test_reset();
    test_frame_scan();
    test_arbitration();
    test_game_write();
    test_game_read();
    test_reset_inflight();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending reads, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
